// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch / data memory) in front of a single-ported
// fixed-latency memory. DM wins by default; a starvation counter forces IF through.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              dm_stall,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              wr_q, wr_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic resp_en, arb_en, if_win, dm_win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            starve_q    <= '0;
            wr_q        <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            wr_q        <= wr_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Arbitration is open in IDLE and in the last WAIT cycle; gated by reset so
    // nothing is granted (or strobed to memory) while reset is held.
    always_comb begin
        resp_en = (state_q == S_WAIT) && (cnt_q == '0);
        arb_en  = reset && ((state_q == S_IDLE) || resp_en);
        dm_win  = arb_en && dm_req && !(if_req && (starve_q == STARVE));
        if_win  = arb_en && if_req && !dm_win;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        starve_d    = starve_q;

        if (resp_en) begin
            if (owner_q == OWN_DM) begin
                dm_rvalid_d = 1'b1;
                dm_rdata_d  = wr_q ? '0 : mem_rdata;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_rdata;
            end
        end

        if (if_win || dm_win) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
            owner_d = dm_win ? OWN_DM : OWN_IF;
            wr_d    = dm_win && dm_we;
        end else if (resp_en) begin
            state_d = S_IDLE;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (!if_req || if_win) begin
            starve_d = '0;
        end else if (dm_win && (starve_q != STARVE)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        if_gnt    = if_win;
        dm_gnt    = dm_win;
        mem_en    = if_win || dm_win;
        mem_we    = dm_win && dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_win) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_win) begin
            mem_addr  = if_addr;
        end
        if_stall  = reset && if_req && !if_win;
        dm_stall  = reset && dm_req && !dm_win;
        busy      = (state_q == S_WAIT);
        if_rvalid = if_rvalid_q;
        dm_rvalid = dm_rvalid_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=2, one at 1,
// each backed by a small delay-line memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          tests = 0;
    int          fails = 0;
    int          proto_viol = 0;

    logic        if_req, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, if_stall, dm_stall, busy;

    logic        if_req1;
    logic [63:0] if_addr1;
    logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1;
    logic [63:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        mem_en1, mem_we1, if_stall1, dm_stall1, busy1;

    logic [63:0] a1 = '0, a2 = '0, b1 = '0;

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a == 64'h10) ? 64'h0050_0093 : (a * 64'd3 + 64'h1000);
    endfunction

    always @(posedge clk) begin
        a1 <= mem_addr;
        a2 <= a1;
        b1 <= mem_addr1;
    end
    assign mem_rdata  = mem_fn(a2);
    assign mem_rdata1 = mem_fn(b1);

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(2), .STARVE_LIMIT(3)) dut (
        .clock(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .dm_stall(dm_stall), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1), .STARVE_LIMIT(3)) dut1 (
        .clock(clk), .reset(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(64'h0), .dm_wdata(64'h0),
        .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .if_stall(if_stall1), .dm_stall(dm_stall1), .busy(busy1)
    );

    // Requests must stay asserted until granted.
    logic pend_if = 1'b0, pend_dm = 1'b0, pend_if1 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_if  <= 1'b0;
            pend_dm  <= 1'b0;
            pend_if1 <= 1'b0;
        end else begin
            if ((pend_if && !if_req) || (pend_dm && !dm_req) || (pend_if1 && !if_req1))
                proto_viol <= proto_viol + 1;
            pend_if  <= if_req && !if_gnt;
            pend_dm  <= dm_req && !dm_gnt;
            pend_if1 <= if_req1 && !if_gnt1;
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Called right after a negedge sample; drops each request once granted.
    task automatic drain;
        logic gi, gd;
        int   n;
        n = 0;
        while ((if_req || dm_req || busy) && n < 40) begin
            gi = if_gnt;
            gd = dm_gnt;
            cyc();
            if (gi) if_req = 1'b0;
            if (gd) dm_req = 1'b0;
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 40) begin
            fails++;
            $display("FAIL drain_timeout: if_req=%0b dm_req=%0b busy=%0b required idle", if_req, dm_req, busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [9:0] outs;
        rst_n   = 1'b0;
        if_req  = 1'b1; if_addr = 64'h18;
        dm_req  = 1'b1; dm_we = 1'b0; dm_addr = 64'h20; dm_wdata = 64'h0;
        if_req1 = 1'b0; if_addr1 = 64'h0;
        @(negedge clk);
        outs = {if_gnt, dm_gnt, mem_en, mem_we, busy, if_rvalid, dm_rvalid, if_stall, dm_stall, |{mem_addr, if_rdata, dm_rdata}};
        tests++;
        if (outs !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0000000000", outs);
        end
        cyc(); rst_n = 1'b1;                       // cycle 0
        @(negedge clk);
        tests++;
        if ({dm_gnt, if_gnt, mem_en, mem_addr} !== {1'b1, 1'b0, 1'b1, 64'h20}) begin
            fails++;
            $display("FAIL reset_first_grant: dm_gnt=%0b if_gnt=%0b mem_en=%0b addr=%h required 1 0 1 20",
                     dm_gnt, if_gnt, mem_en, mem_addr);
        end
        cyc(); dm_req = 1'b0;                      // cycle 1
        @(negedge clk);
        tests++;
        if ({busy, if_stall, if_gnt} !== 3'b110) begin
            fails++;
            $display("FAIL reset_wait: busy/if_stall/if_gnt=%b required 110", {busy, if_stall, if_gnt});
        end
        cyc();                                     // cycle 2
        @(negedge clk);
        tests++;
        if ({if_gnt, mem_addr} !== {1'b1, 64'h18}) begin
            fails++;
            $display("FAIL reset_if_b2b: if_gnt=%0b addr=%h required 1 18", if_gnt, mem_addr);
        end
        cyc(); if_req = 1'b0;                      // cycle 3
        @(negedge clk);
        tests++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, mem_fn(64'h20)}) begin
            fails++;
            $display("FAIL reset_dm_resp: rvalid=%0b rdata=%h required 1 %h", dm_rvalid, dm_rdata, mem_fn(64'h20));
        end
        drain();
    endtask

    task automatic test_if_read;
        cyc(); if_req = 1'b1; if_addr = 64'h10;    // cycle 0
        @(negedge clk);
        tests++;
        if ({if_gnt, mem_en, mem_we, busy, mem_addr} !== {4'b1100, 64'h10}) begin
            fails++;
            $display("FAIL if_grant: gnt/en/we/busy=%b addr=%h required 1100 10", {if_gnt, mem_en, mem_we, busy}, mem_addr);
        end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 1) if_req = 1'b0;
            @(negedge clk);
            tests++;
            if ({if_rvalid, busy} !== {(c == 3), (c == 1 || c == 2)}) begin
                fails++;
                $display("FAIL if_timing c%0d: rvalid=%0b busy=%0b required %0b %0b",
                         c, if_rvalid, busy, (c == 3), (c == 1 || c == 2));
            end
            if (c >= 3) begin
                tests++;
                if (if_rdata !== 64'h0050_0093) begin
                    fails++;
                    $display("FAIL if_rdata c%0d: got %h required 0000000000500093", c, if_rdata);
                end
            end
        end
        drain();
    endtask

    task automatic test_starvation;
        logic exp_if, exp_dm;
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 64'h40;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h48;
            end
            @(negedge clk);
            exp_if = (c % 2 == 0) && ((c / 2) % 4 == 3);
            exp_dm = (c % 2 == 0) && !exp_if;
            tests++;
            if ({if_gnt, dm_gnt, if_stall} !== {exp_if, exp_dm, !exp_if}) begin
                fails++;
                $display("FAIL starve c%0d: if_gnt/dm_gnt/if_stall=%b required %b",
                         c, {if_gnt, dm_gnt, if_stall}, {exp_if, exp_dm, !exp_if});
            end
        end
        drain();
    endtask

    task automatic test_dm_write;
        cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h8; dm_wdata = 64'hDEAD;
        @(negedge clk);
        tests++;
        if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 64'h8, 64'hDEAD}) begin
            fails++;
            $display("FAIL dm_write_grant: gnt/en/we=%b addr=%h wdata=%h required 111 8 dead",
                     {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 1) begin dm_req = 1'b0; dm_we = 1'b0; end
            @(negedge clk);
            tests++;
            if (dm_rvalid !== (c == 3)) begin
                fails++;
                $display("FAIL dm_write_rvalid c%0d: got %0b required %0b", c, dm_rvalid, (c == 3));
            end
        end
        tests++;
        if (dm_rdata !== 64'h0) begin
            fails++;
            $display("FAIL dm_write_rdata: got %h required 0", dm_rdata);
        end
        drain();
    endtask

    task automatic test_reset_midflight;
        int rv_seen;
        rv_seen = 0;
        cyc(); if_req = 1'b1; if_addr = 64'h60;    // cycle 0
        @(negedge clk);
        tests++;
        if (if_gnt !== 1'b1) begin
            fails++;
            $display("FAIL midrst_grant: if_gnt=%0b required 1", if_gnt);
        end
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1) begin if_req = 1'b0; rst_n = 1'b0; end
            if (c == 3) rst_n = 1'b1;
            if (c == 5) begin if_req = 1'b1; if_addr = 64'h68; end
            @(negedge clk);
            if (if_rvalid) rv_seen++;
            if (c == 1 || c == 3) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL midrst_busy c%0d: got %0b required 0", c, busy);
                end
            end
            if (c == 5) begin
                tests++;
                if ({if_gnt, mem_addr} !== {1'b1, 64'h68}) begin
                    fails++;
                    $display("FAIL midrst_regrant: if_gnt=%0b addr=%h required 1 68", if_gnt, mem_addr);
                end
            end
        end
        tests++;
        if (rv_seen !== 0) begin
            fails++;
            $display("FAIL midrst_no_rvalid: saw %0d pulses required 0", rv_seen);
        end
        drain();
    endtask

    task automatic test_latency1;
        logic [63:0] exp_d;
        for (int c = 0; c < 10; c++) begin
            cyc(); if_req1 = 1'b1; if_addr1 = 64'h100 + 64'(8 * c);
            @(negedge clk);
            tests++;
            if ({if_gnt1, if_rvalid1} !== {1'b1, (c >= 2)}) begin
                fails++;
                $display("FAIL lat1 c%0d: gnt/rvalid=%b required 1%0b", c, {if_gnt1, if_rvalid1}, (c >= 2));
            end
            if (c >= 2) begin
                exp_d = mem_fn(64'h100 + 64'(8 * (c - 2)));
                tests++;
                if (if_rdata1 !== exp_d) begin
                    fails++;
                    $display("FAIL lat1_rdata c%0d: got %h required %h", c, if_rdata1, exp_d);
                end
            end
        end
        cyc(); if_req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_protocol;
        tests++;
        if (proto_viol !== 0) begin
            fails++;
            $display("FAIL req_hold: %0d withdrawals required 0", proto_viol);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_starvation();
        test_dm_write();
        test_reset_midflight();
        test_latency1();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port (IF) and the data-memory port (DM).
- Sits between the pipeline's fetch/memory stages and the memory macro.
- Allows one outstanding transaction at a time, with a fixed memory latency.
- DM has priority by default, because it carries the older instruction; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, data width of all ports.
- MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.
- STARVE_LIMIT, 3, consecutive DM grants with IF pending before IF is forced to win; legal range 1..15.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- if_req  in  1  IF read request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  IF read data.
- dm_req  in  1  DM request; held with payload until dm_gnt.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  DM address.
- dm_wdata  in  DATA_W  DM write data.
- dm_gnt  out  1  DM request accepted this cycle.
- dm_rvalid  out  1  one-cycle pulse: read data valid, or write completed.
- dm_rdata  out  DATA_W  DM read data; 0 for writes.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid MEM_LATENCY cycles after the mem_en cycle.
- if_stall  out  1  if_req & ~if_gnt; drives fetch stall.
- dm_stall  out  1  dm_req & ~dm_gnt; drives memory-stage stall.
- busy  out  1  transaction in flight (state WAIT).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, latency counter=0, starve counter=0, owner=IF.
  - if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0, busy=0.
  - Combinational outputs are therefore 0.
  - An in-flight transaction is discarded; no rvalid is ever issued for it after reset releases.
- FSM states:
  - IDLE (accepting).
  - WAIT (counter running).
- Arbitration:
  - Combinational, evaluated in IDLE and in the final WAIT cycle (the cycle with counter==0, where the response is also latched).
  - Winner is DM if dm_req and not (if_req and starve==STARVE_LIMIT); otherwise IF if if_req.
  - In the grant cycle, exactly one of if_gnt/dm_gnt is 1. mem_en=1, and mem_we/mem_addr/mem_wdata are muxed from the winner (mem_we=0 for IF, mem_wdata=0 for IF).
  - Next state is WAIT, counter=MEM_LATENCY-1, owner=winner.
  - If no request: mem_en=0, gnt=0, remain/return to IDLE.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle with counter==0, mem_rdata is registered into the owner's rdata (dm_rdata gets 0 if the transaction was a write), and the owner's rvalid is set for the next cycle.
  - The same cycle re-arbitrates (back-to-back grants allowed).
  - The non-owner's rdata holds its old value.
- Timing for a grant in cycle N:
  - mem_en in cycle N.
  - mem_rdata sampled at the end of cycle N+MEM_LATENCY.
  - rvalid high in cycle N+MEM_LATENCY+1 only.
  - The next grant is possible in cycle N+MEM_LATENCY.
  - Throughput is one transaction per MEM_LATENCY cycles.
- rvalid is a single-cycle pulse. rdata holds until the next response for that port.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each DM grant while if_req=1.
  - Clears on any IF grant.
  - Clears in any cycle with if_req=0.
- Simultaneous events:
  - Both requests with starve<STARVE_LIMIT: DM wins.
  - Both with starve==STARVE_LIMIT: IF wins.
- Request withdrawal before grant is illegal; behaviour is undefined. The bench asserts that req stays high until gnt.
- if_stall and dm_stall are combinational and also cover the WAIT cycles.

Test Plan:
- Reset: hold reset=0 with both reqs high; release at cycle 0, MEM_LATENCY=2.
  -> All outputs 0 during reset; DM granted in cycle 0.
- Single IF read, if_addr=0x10, mem_rdata=0x00500093 in cycle 2.
  -> if_gnt and mem_en in cycle 0; if_rvalid=1 with if_rdata=0x00500093 in cycle 3 only; busy in cycles 1-2.
- Both ports request every cycle, STARVE_LIMIT=3.
  -> Grant sequence DM,DM,DM,IF,DM,DM,DM,IF at cycles 0,2,4,6,...; if_stall=1 between IF grants.
- DM write, dm_we=1, dm_addr=0x8, dm_wdata=0xDEAD.
  -> mem_en=1, mem_we=1, mem_addr=0x8, mem_wdata=0xDEAD in the grant cycle; dm_rvalid pulse 3 cycles later with dm_rdata=0.
- Reset asserted in cycle 1 of an IF read, released in cycle 3.
  -> No if_rvalid ever; state IDLE; next if_req is granted immediately.
- MEM_LATENCY=1 with continuous IF requests.
  -> if_gnt every cycle; if_rvalid every cycle from cycle 2; rdata matches the address sequence.
